instruction_queue: RTL and testbench
====================================

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 Parameter DATA_W, default 8, width of one host bus byte.
REQ-002 Parameter MAX_BYTES, default 4, maximum bytes per instruction, opcode included; minimum 1.
REQ-003 Parameter DEPTH, default 4, number of queued instructions; power of two, minimum 2.
REQ-004 i_clk  in  1  sole clock; all logic on the rising edge.
REQ-005 i_reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_frame_n  in  1  low while the host sends one instruction frame.
REQ-007 i_strobe_n  in  1  low when i_data holds a valid byte; 4-phase with o_ack.
REQ-008 i_data  in  DATA_W  host byte.
REQ-009 o_ack  out  1  byte-accepted handshake.
REQ-010 o_busy  out  1  queue full; host shall not start a new frame.
REQ-011 o_instruction  out  DATA_W*MAX_BYTES  head instruction; all zero when o_valid=0.
REQ-012 o_length  out  clog2(MAX_BYTES+1)  byte count of the head instruction; zero when o_valid=0.
REQ-013 o_valid  out  1  queue non-empty.
REQ-014 i_ready  in  1  consumer pops the head when o_valid=1 and i_ready=1.
REQ-015 o_count  out  clog2(DEPTH+1)  number of queued instructions.
REQ-016 o_err_overflow  out  1  sticky: a frame carried more than MAX_BYTES bytes.
REQ-017 o_err_drop  out  1  sticky: a completed frame was discarded because the queue was full.
REQ-018 i_err_clr  in  1  synchronous clear of both sticky error flags.

Function
REQ-019 Assembler FSM states: IDLE, COLLECT, COMMIT.
REQ-020 IDLE: on i_frame_n=0, clear the assembly register and byte counter, then go to COLLECT.
REQ-021 COLLECT byte capture: when i_strobe_n=0 and o_ack=0, latch i_data and set o_ack=1 on the next edge.
REQ-022 COLLECT ack release: o_ack clears on the first edge with i_strobe_n=1; exactly one byte is captured per strobe-low period.
REQ-023 Byte placement: byte k (k=0 is the opcode) is written to bits [DATA_W*(k+1)-1 : DATA_W*k]; unwritten bytes stay zero.
REQ-024 Overflow: bytes with k >= MAX_BYTES are acked but discarded, and o_err_overflow is set; the stored length saturates at MAX_BYTES.
REQ-025 COLLECT exit: go to COMMIT when i_frame_n=1, i_strobe_n=1 and o_ack=0.
REQ-026 Frame rising while a handshake is open: the FSM stays in COLLECT until that handshake completes.
REQ-027 COMMIT, one cycle, push rule: push {length, data} to the queue if length >= 1 and the queue is not full; then go to IDLE.
REQ-028 COMMIT, zero-byte frame: discard it silently, with no error flagged.
REQ-029 COMMIT, full queue: discard the frame and set o_err_drop.
REQ-030 Full test for a push is (o_count==DEPTH) and not popping in the same cycle; push and pop in the same cycle at full both succeed, and o_count is unchanged.
REQ-031 Queue: circular buffer with read and write pointers that wrap modulo DEPTH.
REQ-032 Queue outputs: o_instruction and o_length are driven from the head entry; o_valid = (o_count != 0).
REQ-033 Latency: o_valid rises on the edge after the COMMIT cycle; frame-end to o_valid is at most 2 cycles after i_frame_n goes high.
REQ-034 Pop: when o_valid=1 and i_ready=1, advance the read pointer; i_ready is ignored when the queue is empty.
REQ-035 o_busy = (o_count == DEPTH), registered together with o_count.
REQ-036 Error flags: i_err_clr clears both flags; if a new error occurs in the same cycle, the set wins.

Reset
REQ-037 While i_reset_n=0, asynchronously force the FSM to IDLE.
REQ-038 While i_reset_n=0, force o_ack, o_valid, o_busy, o_count, both error flags, the pointers, the assembly register and the byte counter to 0.
REQ-039 A reset asserted mid-frame discards the partial instruction.
REQ-040 After reset release, the FSM waits in IDLE for a fresh i_frame_n falling edge; if i_frame_n is already low, a new frame starts from byte 0.
REQ-041 Queue memory contents need no reset; outputs are masked to zero by o_valid=0.

Verification
REQ-042 Single frame: bytes 0x01,0x22,0x33,0x44 sent, then i_frame_n raised -> within 2 cycles o_valid=1, o_instruction=0x44332201, o_length=4.
REQ-043 Short frame: bytes 0x05,0xAA -> o_instruction=0x0000AA05, o_length=2; zero-byte frame -> o_count unchanged, no error.
REQ-044 Overflow: six bytes 0x01..0x06 -> o_instruction=0x04030201, o_length=4, o_err_overflow=1; i_err_clr for one cycle -> flag returns to 0.
REQ-045 Full queue: DEPTH=4 frames with i_ready=0 -> o_busy=1, o_count=4; fifth frame -> dropped, o_err_drop=1; with i_ready=1 held at COMMIT -> push accepted, o_count stays 4.
REQ-046 Ordering and wrap: 10 frames with opcodes 0..9 and a random i_ready pattern -> opcodes popped in order 0..9 with no loss.
REQ-047 Reset mid-frame: i_reset_n pulsed low after 2 bytes -> all outputs 0; the next full frame is assembled correctly from byte 0.

Source files
------------

// File: rtl/instruction_queue.sv
// Instruction queue: assembles host byte frames (4-phase strobe/ack handshake)
// into fixed-width instructions and buffers them in a circular queue for a
// downstream consumer.
module instruction_queue #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_frame_n,
  input  logic                              i_strobe_n,
  input  logic [DATA_W-1:0]                 i_data,
  output logic                              o_ack,
  output logic                              o_busy,
  output logic [DATA_W*MAX_BYTES-1:0]       o_instruction,
  output logic [$clog2(MAX_BYTES+1)-1:0]    o_length,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(DEPTH+1)-1:0]        o_count,
  output logic                              o_err_overflow,
  output logic                              o_err_drop,
  input  logic                              i_err_clr
);

  localparam int INSTR_W = DATA_W * MAX_BYTES;
  localparam int LEN_W   = $clog2(MAX_BYTES + 1);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t               state;
  logic [INSTR_W-1:0]   asm_data;
  logic [LEN_W-1:0]     byte_cnt;

  logic [INSTR_W-1:0]   mem_data [DEPTH];
  logic [LEN_W-1:0]     mem_len  [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     cnt_nxt;

  logic capture;
  logic byte_full;
  logic ovf_set;
  logic full;
  logic pop;
  logic push;
  logic drop_set;

  // A byte is taken once per strobe-low period: strobe low and no ack yet.
  assign capture   = (state == COLLECT) && !i_strobe_n && !o_ack;
  // Once MAX_BYTES have been stored, further bytes are acked but discarded.
  assign byte_full = (byte_cnt == LEN_W'(MAX_BYTES));
  assign ovf_set   = capture && byte_full;

  // A pop in the same cycle frees the slot, so push at full is still legal.
  assign full      = (o_count == CNT_W'(DEPTH));
  assign pop       = o_valid && i_ready;
  assign push      = (state == COMMIT) && (byte_cnt != '0) && (!full || pop);
  assign drop_set  = (state == COMMIT) && (byte_cnt != '0) && full && !pop;

  // Frame assembler: IDLE waits for frame start, COLLECT runs the byte
  // handshake, COMMIT hands the assembled instruction to the queue.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      o_ack    <= 1'b0;
      asm_data <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_ack <= 1'b0;
          if (!i_frame_n) begin
            asm_data <= '0;
            byte_cnt <= '0;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (capture) begin
            o_ack <= 1'b1;
            if (!byte_full) begin
              for (int k = 0; k < MAX_BYTES; k++) begin
                if (byte_cnt == LEN_W'(k)) begin
                  asm_data[k*DATA_W +: DATA_W] <= i_data;
                end
              end
              byte_cnt <= byte_cnt + LEN_W'(1);
            end
          end else if (i_strobe_n && o_ack) begin
            o_ack <= 1'b0;
          end else if (i_frame_n && i_strobe_n && !o_ack) begin
            // Frame end is only honoured once any open handshake has closed.
            state <= COMMIT;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          o_ack <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err_overflow <= 1'b0;
      o_err_drop     <= 1'b0;
    end else begin
      o_err_overflow <= ovf_set  || (o_err_overflow && !i_err_clr);
      o_err_drop     <= drop_set || (o_err_drop     && !i_err_clr);
    end
  end

  // Queue storage: contents are not reset, outputs are masked by o_valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= asm_data;
      mem_len[wr_ptr]  <= byte_cnt;
    end
  end

  // Next occupancy from the push/pop pair of this cycle.
  always_comb begin
    cnt_nxt = o_count;
    if (push && !pop) begin
      cnt_nxt = o_count + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_nxt = o_count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count, valid and
  // busy are registered together so they always agree.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      o_count <= cnt_nxt;
      o_valid <= (cnt_nxt != '0);
      o_busy  <= (cnt_nxt == CNT_W'(DEPTH));
    end
  end

  // Head entry presented to the consumer, zero while the queue is empty.
  always_comb begin
    o_instruction = '0;
    o_length      = '0;
    if (o_valid) begin
      o_instruction = mem_data[rd_ptr];
      o_length      = mem_len[rd_ptr];
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue (DATA_W=8, MAX_BYTES=4, DEPTH=4).
module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_frame_n;
  logic        i_strobe_n;
  logic [7:0]  i_data;
  logic        o_ack;
  logic        o_busy;
  logic [31:0] o_instruction;
  logic [2:0]  o_length;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_count;
  logic        o_err_overflow;
  logic        o_err_drop;
  logic        i_err_clr;

  logic        ready_main = 1'b0;
  logic        ready_rand = 1'b0;
  logic        rand_en    = 1'b0;
  logic [7:0]  fr [8];
  logic [7:0]  captured [$];
  int          errs     = 0;
  int          n_checks = 0;

  assign i_ready = ready_main | ready_rand;

  always #5 clk = ~clk;

  instruction_queue #(.DATA_W(8), .MAX_BYTES(4), .DEPTH(4)) dut (
    .i_clk          (clk),
    .i_reset_n      (i_reset_n),
    .i_frame_n      (i_frame_n),
    .i_strobe_n     (i_strobe_n),
    .i_data         (i_data),
    .o_ack          (o_ack),
    .o_busy         (o_busy),
    .o_instruction  (o_instruction),
    .o_length       (o_length),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_count        (o_count),
    .o_err_overflow (o_err_overflow),
    .o_err_drop     (o_err_drop),
    .i_err_clr      (i_err_clr)
  );

  // Random consumer: the ready value chosen here is used at the next rising
  // edge, so the head seen now is the one that edge pops.
  always @(negedge clk) begin
    if (rand_en) begin
      ready_rand = 1'($urandom_range(0, 1));
      if (ready_rand && o_valid) captured.push_back(o_instruction[7:0]);
    end else begin
      ready_rand = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    i_data = b;
    i_strobe_n = 1'b0;
    t = 0;
    while (!o_ack && t < 20) begin tick(); t++; end
    if (!o_ack) check("ack_rise_timeout", 32'(o_ack), 32'd1);
    i_strobe_n = 1'b1;
    t = 0;
    while (o_ack && t < 20) begin tick(); t++; end
    if (o_ack) check("ack_fall_timeout", 32'(o_ack), 32'd0);
  endtask

  // Raise frame, step into COMMIT, optionally pop during COMMIT, step out.
  task automatic finish_frame(input bit ready_commit);
    i_frame_n = 1'b1;
    tick();
    if (ready_commit) ready_main = 1'b1;
    tick();
    ready_main = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit ready_commit);
    i_frame_n = 1'b0;
    if (n == 0) begin tick(); tick(); end
    for (int i = 0; i < n; i++) send_byte(fr[i]);
    finish_frame(ready_commit);
  endtask

  task automatic pop_one();
    ready_main = 1'b1;
    tick();
    ready_main = 1'b0;
  endtask

  task automatic clear_errs();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
  endtask

  initial begin
    int t;
    i_reset_n = 1'b0; i_frame_n = 1'b1; i_strobe_n = 1'b1;
    i_data = 8'h00; i_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   32'(o_ack), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy",  32'(o_busy), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_instr", o_instruction, 32'd0);
    check("rst_errs",  {30'd0, o_err_overflow, o_err_drop}, 32'd0);
    i_reset_n = 1'b1;
    tick();

    // Full four-byte frame
    fr[0] = 8'h01; fr[1] = 8'h22; fr[2] = 8'h33; fr[3] = 8'h44;
    send_frame(4, 1'b0);
    check("f1_valid", 32'(o_valid), 32'd1);
    check("f1_instr", o_instruction, 32'h44332201);
    check("f1_len",   32'(o_length), 32'd4);
    check("f1_count", 32'(o_count), 32'd1);
    pop_one();
    check("f1_pop_count", 32'(o_count), 32'd0);
    check("f1_pop_instr", o_instruction, 32'd0);

    // Short frame then empty frame
    fr[0] = 8'h05; fr[1] = 8'hAA;
    send_frame(2, 1'b0);
    check("short_instr", o_instruction, 32'h0000AA05);
    check("short_len",   32'(o_length), 32'd2);
    pop_one();
    send_frame(0, 1'b0);
    tick();
    check("zero_count", 32'(o_count), 32'd0);
    check("zero_valid", 32'(o_valid), 32'd0);
    check("zero_errs",  {30'd0, o_err_overflow, o_err_drop}, 32'd0);

    // Overflowing six-byte frame
    for (int i = 0; i < 6; i++) fr[i] = 8'(i + 1);
    send_frame(6, 1'b0);
    check("ovf_instr", o_instruction, 32'h04030201);
    check("ovf_len",   32'(o_length), 32'd4);
    check("ovf_flag",  32'(o_err_overflow), 32'd1);
    check("ovf_nodrop", 32'(o_err_drop), 32'd0);
    pop_one();
    clear_errs();
    check("ovf_cleared", 32'(o_err_overflow), 32'd0);

    // Fill the queue, drop one, then push+pop at full
    for (int i = 0; i < 4; i++) begin
      fr[0] = 8'(8'h10 + i);
      send_frame(1, 1'b0);
    end
    check("full_busy",  32'(o_busy), 32'd1);
    check("full_count", 32'(o_count), 32'd4);
    check("full_head",  o_instruction, 32'h10);
    check("full_len",   32'(o_length), 32'd1);
    fr[0] = 8'h14;
    send_frame(1, 1'b0);
    check("drop_flag",  32'(o_err_drop), 32'd1);
    check("drop_count", 32'(o_count), 32'd4);
    check("drop_head",  o_instruction, 32'h10);
    clear_errs();
    check("drop_cleared", 32'(o_err_drop), 32'd0);
    fr[0] = 8'h15;
    send_frame(1, 1'b1);
    check("pp_count", 32'(o_count), 32'd4);
    check("pp_busy",  32'(o_busy), 32'd1);
    check("pp_nodrop", 32'(o_err_drop), 32'd0);
    check("pp_head",  o_instruction, 32'h11);
    pop_one();
    check("drain_busy", 32'(o_busy), 32'd0);
    check("drain_h1", o_instruction, 32'h12);
    pop_one();
    check("drain_h2", o_instruction, 32'h13);
    pop_one();
    check("drain_h3", o_instruction, 32'h15);
    pop_one();
    check("drain_count", 32'(o_count), 32'd0);

    // Ordering and pointer wrap with a random consumer
    captured.delete();
    rand_en = 1'b1;
    for (int op = 0; op < 10; op++) begin
      t = 0;
      while (o_busy && t < 100) begin tick(); t++; end
      if (o_busy) check("ord_busy_timeout", 32'(o_busy), 32'd0);
      fr[0] = 8'(op);
      send_frame(1, 1'b0);
    end
    t = 0;
    while (captured.size() < 10 && t < 300) begin tick(); t++; end
    rand_en = 1'b0;
    tick();
    check("ord_size", 32'(captured.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < captured.size()) check($sformatf("ord_op%0d", i), 32'(captured[i]), 32'(i));
    end
    check("ord_nodrop", 32'(o_err_drop), 32'd0);
    check("ord_empty",  32'(o_count), 32'd0);

    // Reset in the middle of a frame with one entry queued
    fr[0] = 8'h77;
    send_frame(1, 1'b0);
    check("pre_rst_count", 32'(o_count), 32'd1);
    i_frame_n = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(o_count), 32'd0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_instr", o_instruction, 32'd0);
    check("mid_rst_misc",  {28'd0, o_ack, o_busy, o_err_overflow, o_err_drop}, 32'd0);
    tick();
    i_reset_n = 1'b1;
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    finish_frame(1'b0);
    check("post_rst_instr", o_instruction, 32'hD4C3B2A1);
    check("post_rst_len",   32'(o_length), 32'd4);
    check("post_rst_count", 32'(o_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, n_checks);
    $finish;
  end

endmodule
